axis_fifo_uart_rx: RTL and testbench
====================================

# axis_fifo_uart_rx

UART receiver that deserializes an 8N1 serial line, buffers received words in a synchronous FIFO, and presents them as an AXI-Stream master. It is the receive-side counterpart of the FIFO-buffered UART transmit path and sits between the board RX pin and the on-chip stream consumer. Framing errors and FIFO overruns are reported as single-cycle pulses.

## Interface
- WIDTH, 8: data bits per UART frame and AXIS data width
- DEPTH, 8: FIFO entries (power of two, >= 2)
- CLK_RATE, 100000000: clk frequency in Hz
- BAUD, 115200: line rate in bits/s
- IDLE_BITS, 2: idle bit-times after a stop bit that close a packet (tlast)

- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset; one clock domain only
- uart_rx  input  1  serial line, idle high, asynchronous to clk
- m_axis_data  output  WIDTH  received word, LSB first on the line
- m_axis_valid  output  1  FIFO non-empty
- m_axis_last  output  1  word is last of a packet (idle-gap delimited)
- m_axis_ready  input  1  consumer accepts word
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: word dropped, FIFO full

## Operation
- uart_rx passes a 2-flop synchronizer (reset value 1) before any use.
- BIT_CYC = CLK_RATE/BAUD (integer floor); HALF = BIT_CYC/2. Bit counter width = $clog2(BIT_CYC).
- FSM: IDLE -> START on synchronized falling edge; START waits HALF cycles, line still low -> DATA, else -> IDLE (glitch rejected, no error). DATA samples WIDTH bits each BIT_CYC apart, shifting LSB first -> STOP. STOP samples after BIT_CYC: high -> word complete, low -> frame_err pulse, word discarded; both -> IDLE.
- Word complete: pushed to FIFO (see Configuration for tlast hold). If FIFO full at push: word dropped, overrun pulses, FIFO contents untouched.
- Output: m_axis_valid = !empty; m_axis_data/last show FIFO head (first-word-fall-through); pop on valid && ready. Push and pop in same cycle when full is allowed only if pop frees a slot first (no overrun on simultaneous full+pop).
- Data/last stable while valid && !ready.

## Timing
- Reset: m_axis_valid 0, m_axis_data 0, m_axis_last 0, frame_err 0, overrun 0, FSM IDLE, FIFO empty.
- Reset mid-frame: partial word discarded; after release, FSM waits in IDLE for next falling edge.
- Start edge at cycle 0 (synchronized); stop sample at 2 + HALF + WIDTH*BIT_CYC + BIT_CYC cycles from the raw edge, +/-1.
- Push one cycle after stop sample (feature off); m_axis_valid rises the next cycle.
- frame_err/overrun: asserted exactly one cycle, cycle after stop sample.

## Configuration
- UART_RX_IDLE_LAST_EN defined: completed word held in a one-entry holding register. Pushed with last=0 when the next start edge is detected; pushed with last=1 after IDLE_BITS*BIT_CYC idle cycles from its stop sample. A framing error flushes the held word with last=1 before reporting. Overrun applies at the held-word push.
- Not defined: no holding register, words pushed immediately, m_axis_last tied 0, IDLE_BITS unused.

## Structure
- Shared package: BIT_CYC/HALF derivation function, FSM state enum (IDLE, START, DATA, STOP), pointer-width helper.
- One sub-module natural: uart_rx (synchronizer, FSM, shift register, error detect); top instantiates uart_rx plus the existing sync_fifo (with last bit) and holds tlast logic.

## Test plan
- CLK_RATE=1600000, BAUD=100000 (BIT_CYC=16): send 0xA5, ready=1 -> one beat data 0xA5, valid within 1 cycle of push, no error pulses.
- Send 0x3C with stop bit low -> frame_err pulses once, no beat output.
- 4-cycle low glitch on idle line -> FSM returns IDLE, no output, no error.
- ready=0, send DEPTH+1 bytes 0x00..0x08 -> 8 stored, overrun pulses once on 0x08; then ready=1 drains 0x00..0x07 in order.
- UART_RX_IDLE_LAST_EN: send 0x11,0x22,0x33 back-to-back then idle 3 bit-times -> beats 0x11/0x22 last=0, 0x33 last=1.
- Assert rst low mid-DATA of 0x5A, release, send 0x77 -> only 0x77 output, all outputs 0 during reset.

Source files
------------

// File: rtl/axis_fifo_uart_rx_pkg.sv
// Shared definitions for the FIFO-buffered UART receiver: bit-timing
// derivation, receiver FSM states and FIFO pointer sizing.
package axis_fifo_uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clocks per bit; integer floor of the clock/baud ratio.
    function automatic int bit_cycles(input int clk_rate, input int baud);
        return clk_rate / baud;
    endfunction

    function automatic int half_cycles(input int bit_cyc);
        return bit_cyc / 2;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write when full is accepted
// only if a read in the same cycle frees a slot.
module sync_fifo
    import axis_fifo_uart_rx_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // NOTE: the storage array is deliberately left without reset; only the
    // pointers and count define what is valid, and the array maps to RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial deserializer: input synchronizer, start/data/stop FSM,
// LSB-first shift register, framing-error detection.
module uart_rx
    import axis_fifo_uart_rx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CLK_RATE = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    output logic             frame_err,
    output logic             start_det
);

    localparam int BIT_CYC = bit_cycles(CLK_RATE, BAUD);
    localparam int HALF    = half_cycles(BIT_CYC);
    localparam int CW      = $clog2(BIT_CYC);
    localparam int BW      = $clog2(WIDTH);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(WIDTH - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             fall;
    logic             tick;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] shift;

    // NOTE: the synchronizer flops reset to the idle-high line level so that
    // releasing reset never manufactures a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall      = rx_prev & ~rx_sync;
    assign start_det = (state == IDLE) && fall;

    // NOTE: every output of this block is given a default before the case so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        case (state)
            IDLE: begin
                if (fall) state_nxt = START;
            end
            START: begin
                tick = (cnt == HALF_LAST);
                if (tick) state_nxt = rx_sync ? IDLE : DATA;
            end
            DATA: begin
                tick = (cnt == BIT_LAST);
                if (tick && bit_idx == IDX_LAST) state_nxt = STOP;
            end
            STOP: begin
                tick = (cnt == BIT_LAST);
                if (tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (state == IDLE || tick) cnt <= '0;
            else                       cnt <= cnt + CW'(1);

            if (state != DATA) bit_idx <= '0;
            else if (tick)     bit_idx <= bit_idx + BW'(1);

            if (state == DATA && tick) shift <= {rx_sync, shift[WIDTH-1:1]};

            // Stop-bit verdict is reported the cycle after the sample.
            word_valid <= (state == STOP) && tick && rx_sync;
            frame_err  <= (state == STOP) && tick && !rx_sync;
        end
    end

    assign word_data = shift;

endmodule

// File: rtl/axis_fifo_uart_rx.sv
// UART receiver feeding a FIFO presented as an AXI-Stream master.
// Define UART_RX_IDLE_LAST_EN to mark packet ends (tlast) by idle gaps.
module axis_fifo_uart_rx
    import axis_fifo_uart_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int CLK_RATE  = 100000000,
    parameter int BAUD      = 115200,
    parameter int IDLE_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    output logic [WIDTH-1:0] m_axis_data,
    output logic             m_axis_valid,
    output logic             m_axis_last,
    input  logic             m_axis_ready,
    output logic             frame_err,
    output logic             overrun
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (IDLE_BITS < 1) begin : g_bad_idle
        $error("IDLE_BITS must be at least 1");
    end

    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             start_det;
    logic             push_req;
    logic [WIDTH-1:0] push_data;
    logic             push_last;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH:0]   head;

    uart_rx #(
        .WIDTH    (WIDTH),
        .CLK_RATE (CLK_RATE),
        .BAUD     (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx),
        .word_data  (word_data),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .start_det  (start_det)
    );

`ifdef UART_RX_IDLE_LAST_EN
    localparam int BIT_CYC  = bit_cycles(CLK_RATE, BAUD);
    localparam int IDLE_TOT = IDLE_BITS * BIT_CYC;
    localparam int IW       = $clog2(IDLE_TOT + 1);

    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic [IW-1:0]    idle_cnt;
    logic             idle_done;

    // idle_cnt equals the number of cycles since the held word's stop sample.
    assign idle_done = (idle_cnt == IW'(IDLE_TOT));

    always_comb begin
        push_req  = 1'b0;
        push_data = hold_data;
        push_last = 1'b0;
        if (hold_valid) begin
            if (frame_err || (idle_done && !start_det)) begin
                push_req  = 1'b1;
                push_last = 1'b1;
            end else if (start_det) begin
                push_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            idle_cnt   <= '0;
        end else begin
            if (push_req) hold_valid <= 1'b0;
            if (word_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= word_data;
                idle_cnt   <= IW'(2);
            end else if (hold_valid && !idle_done) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end
`else
    logic unused_start_det;

    assign unused_start_det = start_det;
    assign push_req         = word_valid;
    assign push_data        = word_data;
    assign push_last        = 1'b0;
`endif

    assign pop = m_axis_valid & m_axis_ready;

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_req),
        .wr_data ({push_last, push_data}),
        .full    (full),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (empty)
    );

    // A pop in the same cycle frees the slot, so only a blocked push overruns.
    assign overrun      = push_req & full & ~pop;
    assign m_axis_valid = ~empty;
    assign m_axis_data  = m_axis_valid ? head[WIDTH-1:0] : '0;
    assign m_axis_last  = m_axis_valid & head[WIDTH];

endmodule

// File: tb/tb_axis_fifo_uart_rx.sv
// Scoreboard bench for axis_fifo_uart_rx at 16 clocks per bit; expected beats
// are queued by the stimulus and checked by an independent output monitor.
module tb_axis_fifo_uart_rx;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 8;
    localparam int CLK_RATE  = 1600000;
    localparam int BAUD      = 100000;
    localparam int IDLE_BITS = 2;
    localparam int BIT_CYC   = 16;
    localparam int SETTLE    = 60;
`ifdef UART_RX_IDLE_LAST_EN
    localparam logic LAST_EN = 1'b1;
`else
    localparam logic LAST_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_line = 1'b1;
    logic       m_axis_ready = 1'b0;
    logic [7:0] m_axis_data;
    logic       m_axis_valid;
    logic       m_axis_last;
    logic       frame_err;
    logic       overrun;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    fe_cnt   = 0;
    int    ov_cnt   = 0;
    int    beat_cnt = 0;

    axis_fifo_uart_rx #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .CLK_RATE  (CLK_RATE),
        .BAUD      (BAUD),
        .IDLE_BITS (IDLE_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (rx_line),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake and tallies pulses.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (m_axis_valid && m_axis_ready) begin
                beat_t e;
                beat_cnt++;
                check("beat_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", int'(m_axis_data), int'(e.data));
                    check("beat_last", int'(m_axis_last), int'(e.last));
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(posedge clk); #1;
        rx_line = b;
        repeat (BIT_CYC - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        if (!stop_bit) begin
            @(posedge clk); #1;
            rx_line = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, ov0, bt0, lat;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(m_axis_valid), 0);
        check("rst_data", int'(m_axis_data), 0);
        check("rst_last", int'(m_axis_last), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        m_axis_ready = 1'b1;
        repeat (5) @(posedge clk);

        // Single byte, consumer always ready
        fe0 = fe_cnt; ov0 = ov_cnt; bt0 = beat_cnt;
        exp_q.push_back('{data: 8'hA5, last: LAST_EN});
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                @(posedge clk); #1;
                while (!m_axis_valid && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        settle();
`ifndef UART_RX_IDLE_LAST_EN
        check_range("a5_valid_latency", lat, 155, 159);
`endif
        check("a5_beats", beat_cnt - bt0, 1);
        check("a5_no_frame_err", fe_cnt - fe0, 0);
        check("a5_no_overrun", ov_cnt - ov0, 0);

        // Stop bit low: framing error, no beat
        fe0 = fe_cnt; bt0 = beat_cnt;
        send_byte(8'h3C, 1'b0);
        settle();
        check("fe_pulse_cycles", fe_cnt - fe0, 1);
        check("fe_no_beat", beat_cnt - bt0, 0);

        // Short glitch on idle line is rejected silently
        fe0 = fe_cnt; bt0 = beat_cnt;
        @(posedge clk); #1;
        rx_line = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_line = 1'b1;
        settle();
        check("glitch_no_beat", beat_cnt - bt0, 0);
        check("glitch_no_err", fe_cnt - fe0, 0);
        check("glitch_valid_low", int'(m_axis_valid), 0);

        // Fill with consumer stalled, then overrun on the ninth word
        @(posedge clk); #1;
        m_axis_ready = 1'b0;
        ov0 = ov_cnt; bt0 = beat_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{data: 8'(i), last: 1'b0});
            send_byte(8'(i), 1'b1);
        end
        @(negedge clk);
        check("fill_no_overrun_yet", ov_cnt - ov0, 0);
        check("fill_valid", int'(m_axis_valid), 1);
        check("fill_head_stable", int'(m_axis_data), 0);
        send_byte(8'h08, 1'b1);
        settle();
        check("overrun_pulse_cycles", ov_cnt - ov0, 1);
        check("stall_head_stable", int'(m_axis_data), 0);
        check("stall_no_beats", beat_cnt - bt0, 0);
        @(posedge clk); #1;
        m_axis_ready = 1'b1;
        settle();
        check("drain_beats", beat_cnt - bt0, DEPTH);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_valid_low", int'(m_axis_valid), 0);

        // Back-to-back packet followed by an idle gap
        bt0 = beat_cnt;
        exp_q.push_back('{data: 8'h11, last: 1'b0});
        exp_q.push_back('{data: 8'h22, last: 1'b0});
        exp_q.push_back('{data: 8'h33, last: LAST_EN});
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        repeat (3 * BIT_CYC) @(posedge clk);
        settle();
        check("pkt_beats", beat_cnt - bt0, 3);

        // Reset in the middle of a data phase, then a clean byte
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #1;
        rst = 1'b0;
        rx_line = 1'b1;
        @(negedge clk);
        check("midrst_valid", int'(m_axis_valid), 0);
        check("midrst_data", int'(m_axis_data), 0);
        check("midrst_last", int'(m_axis_last), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        check("midrst_overrun", int'(overrun), 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        bt0 = beat_cnt; fe0 = fe_cnt;
        settle();
        check("midrst_quiet_after_release", int'(m_axis_valid), 0);
        exp_q.push_back('{data: 8'h77, last: LAST_EN});
        send_byte(8'h77, 1'b1);
        settle();
        check("midrst_beats", beat_cnt - bt0, 1);
        check("midrst_no_err", fe_cnt - fe0, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
